de4_sopc_st_packet_arbiter: RTL and testbench

DE4_SOPC_ST_PACKET_ARBITER -- requirements
Module: de4_sopc_st_packet_arbiter

---
 rtl/de4_sopc_st_pkg.sv | 16 +
 rtl/de4_sopc_st_out_reg.sv | 67 ++++++
 rtl/de4_sopc_st_packet_arbiter.sv | 148 ++++++++++++++
 tb/tb_de4_sopc_st_packet_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/de4_sopc_st_pkg.sv
// Shared definitions for the two-requester Avalon-ST packet arbiter.
package de4_sopc_st_pkg;
   localparam int CH_W   = 1;
   localparam int DROP_W = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PKT0 = 2'd1,
      ST_PKT1 = 2'd2
   } arb_state_e;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == DROP_MAX) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/de4_sopc_st_out_reg.sv
// One-deep Avalon-ST output register; reloads whenever empty or being drained.
module de4_sopc_st_out_reg
   import de4_sopc_st_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_error,
   input  logic               i_sop,
   input  logic               i_eop,
   input  logic [EMPTY_W-1:0] i_empty,
   input  logic [CH_W-1:0]    i_channel,
   input  logic               i_ready,
   output logic               o_accept,
   output logic               o_valid,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_error,
   output logic               o_sop,
   output logic               o_eop,
   output logic [EMPTY_W-1:0] o_empty,
   output logic [CH_W-1:0]    o_channel
);
   logic               r_valid;
   logic [DATA_W-1:0]  r_data;
   logic               r_error;
   logic               r_sop;
   logic               r_eop;
   logic [EMPTY_W-1:0] r_empty;
   logic [CH_W-1:0]    r_channel;

   assign o_accept = !r_valid || i_ready;

   // Payload only moves on a load so a stalled beat stays bit-stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_error   <= 1'b0;
         r_sop     <= 1'b0;
         r_eop     <= 1'b0;
         r_empty   <= '0;
         r_channel <= '0;
      end else if (o_accept) begin
         r_valid <= i_load;
         if (i_load) begin
            r_data    <= i_data;
            r_error   <= i_error;
            r_sop     <= i_sop;
            r_eop     <= i_eop;
            r_empty   <= i_empty;
            r_channel <= i_channel;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_error   = r_error;
   assign o_sop     = r_sop;
   assign o_eop     = r_eop;
   assign o_empty   = r_empty;
   assign o_channel = r_channel;
endmodule

// File: rtl/de4_sopc_st_packet_arbiter.sv
// Packet-granular round-robin merge of two Avalon-ST sinks onto one source;
// non-SOP beats seen while idle are swallowed and counted.
module de4_sopc_st_packet_arbiter
   import de4_sopc_st_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in0_valid,
   input  logic [DATA_W-1:0]  in0_data,
   input  logic               in0_error,
   input  logic               in0_startofpacket,
   input  logic               in0_endofpacket,
   input  logic [EMPTY_W-1:0] in0_empty,
   output logic               in0_ready,
   input  logic               in1_valid,
   input  logic [DATA_W-1:0]  in1_data,
   input  logic               in1_error,
   input  logic               in1_startofpacket,
   input  logic               in1_endofpacket,
   input  logic [EMPTY_W-1:0] in1_empty,
   output logic               in1_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_error,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_channel,
   output logic [DROP_W-1:0]  drop_count
);
   arb_state_e          r_state, w_state_nxt;
   logic [CH_W-1:0]     r_last, w_last_nxt;
   logic [DROP_W-1:0]   r_drop;
   logic                w_accept;
   logic                w_grant;
   logic [CH_W-1:0]     w_pick;
   logic                w_elig0, w_elig1;
   logic                w_valid, w_sop, w_eop, w_error;
   logic [DATA_W-1:0]   w_data;
   logic [EMPTY_W-1:0]  w_empty;
   logic                w_xfer, w_fwd, w_drop;

   assign w_elig0 = in0_valid & in0_startofpacket;
   assign w_elig1 = in1_valid & in1_startofpacket;

   // Grant selection: a packet owner keeps the port regardless of its valid;
   // when idle, SOPs beat orphans and orphans are taken lowest index first.
   always_comb begin
      w_pick  = '0;
      w_grant = 1'b0;
      case (r_state)
         ST_PKT0: begin w_pick = 1'b0; w_grant = 1'b1; end
         ST_PKT1: begin w_pick = 1'b1; w_grant = 1'b1; end
         default: begin
            if (w_elig0 && (!w_elig1 || r_last == 1'b1)) begin
               w_pick = 1'b0; w_grant = 1'b1;
            end else if (w_elig1) begin
               w_pick = 1'b1; w_grant = 1'b1;
            end else if (in0_valid) begin
               w_pick = 1'b0; w_grant = 1'b1;
            end else if (in1_valid) begin
               w_pick = 1'b1; w_grant = 1'b1;
            end
         end
      endcase
   end

   assign w_valid = w_pick ? in1_valid         : in0_valid;
   assign w_sop   = w_pick ? in1_startofpacket : in0_startofpacket;
   assign w_eop   = w_pick ? in1_endofpacket   : in0_endofpacket;
   assign w_error = w_pick ? in1_error         : in0_error;
   assign w_data  = w_pick ? in1_data          : in0_data;
   assign w_empty = w_pick ? in1_empty         : in0_empty;

   assign in0_ready = w_accept & ~reset & w_grant & (w_pick == 1'b0);
   assign in1_ready = w_accept & ~reset & w_grant & (w_pick == 1'b1);
   assign w_xfer    = w_accept & ~reset & w_grant & w_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_fwd       = 1'b0;
      w_drop      = 1'b0;
      if (w_xfer) begin
         case (r_state)
            ST_IDLE: begin
               if (w_sop) begin
                  w_fwd = 1'b1;
                  if (w_eop) w_last_nxt  = w_pick;
                  else       w_state_nxt = w_pick ? ST_PKT1 : ST_PKT0;
               end else begin
                  w_drop = 1'b1;
               end
            end
            default: begin
               // A stray SOP inside a packet is just payload.
               w_fwd = 1'b1;
               if (w_eop) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = w_pick;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_drop  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         if (w_drop) r_drop <= sat_inc(r_drop);
      end
   end

   assign drop_count = r_drop;

   de4_sopc_st_out_reg #(
      .DATA_W  (DATA_W),
      .EMPTY_W (EMPTY_W)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_fwd),
      .i_data    (w_data),
      .i_error   (w_error),
      .i_sop     (w_sop),
      .i_eop     (w_eop),
      .i_empty   (w_empty),
      .i_channel (w_pick),
      .i_ready   (out_ready),
      .o_accept  (w_accept),
      .o_valid   (out_valid),
      .o_data    (out_data),
      .o_error   (out_error),
      .o_sop     (out_startofpacket),
      .o_eop     (out_endofpacket),
      .o_empty   (out_empty),
      .o_channel (out_channel)
   );
endmodule

// File: tb/tb_de4_sopc_st_packet_arbiter.sv
// Randomized bench for the packet arbiter with a rule-level reference model.
module tb_de4_sopc_st_packet_arbiter;
   localparam int DW = 32;
   localparam int EW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]         tv, tsop, teop, terr;
   logic [1:0][DW-1:0] tdat;
   logic [1:0][EW-1:0] temp;
   logic               in0_ready, in1_ready;
   logic               out_valid, out_error, out_startofpacket, out_endofpacket;
   logic [DW-1:0]      out_data;
   logic [EW-1:0]      out_empty;
   logic               out_ready;
   logic [0:0]         out_channel;
   logic [7:0]         drop_count;

   de4_sopc_st_packet_arbiter #(.DATA_W(DW), .EMPTY_W(EW)) dut (
      .clk(clk), .reset(reset),
      .in0_valid(tv[0]), .in0_data(tdat[0]), .in0_error(terr[0]),
      .in0_startofpacket(tsop[0]), .in0_endofpacket(teop[0]), .in0_empty(temp[0]),
      .in0_ready(in0_ready),
      .in1_valid(tv[1]), .in1_data(tdat[1]), .in1_error(terr[1]),
      .in1_startofpacket(tsop[1]), .in1_endofpacket(teop[1]), .in1_empty(temp[1]),
      .in1_ready(in1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty), .out_ready(out_ready),
      .out_channel(out_channel), .drop_count(drop_count)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: owner of the port (-1 = none), last served, drops, output beat.
   int            m_own, m_last, m_drop;
   bit            m_ov, m_oerr, m_osop, m_oeop, m_och;
   logic [DW-1:0] m_od;
   logic [EW-1:0] m_oemp;

   // Stimulus generator state.
   int rem[2];
   int pval[2];
   bit orph_only[2];
   int fix_len, orph_pct;

   task automatic model_reset();
      m_own = -1; m_last = 1; m_drop = 0;
      m_ov = 0; m_oerr = 0; m_osop = 0; m_oeop = 0; m_och = 0;
      m_od = '0; m_oemp = '0;
   endtask

   task automatic new_beat(input int ch);
      int len;
      tv[ch]   = 1'b1;
      tdat[ch] = $urandom;
      terr[ch] = ($urandom_range(15) == 0);
      temp[ch] = EW'($urandom);
      if (orph_only[ch]) begin
         tsop[ch] = 1'b0; teop[ch] = 1'($urandom);
      end else if (rem[ch] == 0) begin
         if (int'($urandom_range(99)) < orph_pct) begin
            tsop[ch] = 1'b0; teop[ch] = 1'($urandom);
         end else begin
            len = (fix_len != 0) ? fix_len : int'($urandom_range(4, 1));
            tsop[ch] = 1'b1; teop[ch] = (len == 1); rem[ch] = len - 1;
         end
      end else begin
         rem[ch]--;
         tsop[ch] = 1'b0; teop[ch] = (rem[ch] == 0);
      end
   endtask

   task automatic refill(input logic [1:0] xf);
      for (int ch = 0; ch < 2; ch++)
         if (!tv[ch] || xf[ch]) begin
            if (int'($urandom_range(99)) < pval[ch]) new_beat(ch);
            else tv[ch] = 1'b0;
         end
   endtask

   // One clock: check outputs and readies mid-cycle, advance the model at the edge.
   task automatic cycle();
      bit acc;
      int pick;
      logic [1:0] rdy, xf;
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (m_ov) begin
         chk("out_data", 64'(out_data), 64'(m_od));
         chk("out_channel", 64'(out_channel), 64'(m_och));
         chk("out_sop", 64'(out_startofpacket), 64'(m_osop));
         chk("out_eop", 64'(out_endofpacket), 64'(m_oeop));
         chk("out_error", 64'(out_error), 64'(m_oerr));
         chk("out_empty", 64'(out_empty), 64'(m_oemp));
      end
      acc = !m_ov || out_ready;
      pick = -1;
      rdy = 2'b00;
      if (!reset) begin
         if (m_own >= 0) pick = m_own;
         else if (tv[0] && tsop[0] && tv[1] && tsop[1]) pick = (m_last == 0) ? 1 : 0;
         else if (tv[0] && tsop[0]) pick = 0;
         else if (tv[1] && tsop[1]) pick = 1;
         else if (tv[0]) pick = 0;
         else if (tv[1]) pick = 1;
         if (pick >= 0 && acc) rdy[pick] = 1'b1;
      end
      chk("in0_ready", 64'(in0_ready), 64'(rdy[0]));
      chk("in1_ready", 64'(in1_ready), 64'(rdy[1]));
      xf = rdy & tv;
      @(posedge clk);
      if (reset) model_reset();
      else begin
         if (acc) m_ov = 0;
         if (pick >= 0 && xf[pick]) begin
            if (m_own >= 0 || tsop[pick]) begin
               m_ov = 1; m_od = tdat[pick]; m_oerr = terr[pick];
               m_osop = tsop[pick]; m_oeop = teop[pick]; m_oemp = temp[pick];
               m_och = pick[0];
            end else if (m_drop < 255) m_drop++;
            if (m_own >= 0) begin
               if (teop[pick]) begin m_own = -1; m_last = pick; end
            end else if (tsop[pick]) begin
               if (teop[pick]) m_last = pick;
               else m_own = pick;
            end
         end
      end
      #1;
      refill(xf);
   endtask

   task automatic do_reset();
      pval[0] = 0; pval[1] = 0;
      orph_only[0] = 0; orph_only[1] = 0;
      tv = '0; rem[0] = 0; rem[1] = 0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] seq;
      bit         allv;
      tv = '0; tsop = '0; teop = '0; terr = '0; tdat = '0; temp = '0;
      fix_len = 0; orph_pct = 0;
      out_ready = 1'b1;
      model_reset();
      do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_flags", 64'({out_error, out_startofpacket, out_endofpacket, out_empty, out_channel}), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);

      // Two simultaneous 3-beat packets: requester 0 first, no bubbles.
      fix_len = 3; orph_pct = 0; pval[0] = 100; pval[1] = 100;
      refill(2'b00);
      seq = '0; allv = 1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         seq = {seq[4:0], out_channel[0]};
         allv &= out_valid;
      end
      chk("order_000111", 64'(seq), 64'(6'b000111));
      chk("no_gap", 64'(allv), 64'd1);

      // Single-beat packets from both sides interleave strictly.
      do_reset();
      fix_len = 1; pval[0] = 100; pval[1] = 100;
      refill(2'b00);
      for (int k = 1; k <= 12; k++) begin
         cycle();
         chk("alt_valid", 64'(out_valid), 64'd1);
         chk("alt_chan", 64'(out_channel), 64'((k - 1) & 1));
      end

      // Orphan flood on requester 0 saturates the drop counter.
      do_reset();
      orph_only[0] = 1; pval[0] = 100;
      refill(2'b00);
      for (int k = 0; k < 300; k++) begin
         out_ready = ($urandom_range(1) == 1);
         cycle();
      end
      chk("drop_sat", 64'(drop_count), 64'd255);
      out_ready = 1'b1;

      // Reset after beat 2 of a 4-beat packet: tail beats become orphans.
      do_reset();
      fix_len = 4; pval[0] = 100;
      refill(2'b00);
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_mid_ov", 64'(out_valid), 64'd0);
      cycle();
      pval[0] = 0;
      cycle();
      cycle();
      chk("rst_mid_drop", 64'(drop_count), 64'd2);

      // Random traffic with backpressure, orphans and occasional reset.
      do_reset();
      fix_len = 0; orph_pct = 10; pval[0] = 70; pval[1] = 70;
      refill(2'b00);
      for (int k = 0; k < 4000; k++) begin
         out_ready = ($urandom_range(99) < 65);
         reset = ($urandom_range(599) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
